// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// ----------------------------------------------------------------------------
// Sequencer between the CPU datapath and a unified 32-bit word memory. The
// memory reads combinationally and writes on the rising clock edge. The unit
// accepts one byte, half or word load/store at a time through a valid/ready
// handshake. It rejects misaligned, out-of-range, illegal-size and
// instruction-region stores. It sign- or zero-extends load data and performs
// read-modify-write for sub-word stores. Every accepted request produces
// exactly one single-cycle response pulse.
//
// Ports
//   clk               in   1   clock, all state updates on posedge
//   reset_n           in   1   asynchronous active-low reset
//   req_valid         in   1   request present, held stable until accepted
//   req_ready         out  1   high only while idle
//   req_write         in   1   1 = store, 0 = load
//   req_size          in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_signed        in   1   loads: sign-extend when set
//   req_addr          in   32  byte address
//   req_wdata         in   32  right-justified store data
//   resp_valid        out  1   one-cycle completion pulse
//   resp_error        out  1   request rejected, memory untouched
//   resp_rdata        out  32  load result, 0 for stores and errors
//   mem_write_enable  out  1   memory write strobe (WRITE state only)
//   mem_address       out  32  word-aligned byte address to memory
//   mem_write_data    out  32  full word to write
//   mem_read_data     in   32  combinational read word from memory
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 512,
    parameter int DATA_BASE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [31:0] DATA_LIMIT = 32'(DATA_BASE);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      state;

    // Request fields captured at acceptance. Only the low half of the store
    // data is kept: word stores write req_wdata straight into mem_write_data
    // on the accept edge, so the upper half is never needed later.
    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [1:0]  cap_lane;
    logic [15:0] cap_wdata;

    logic        req_error;

    // Legality checks on the incoming request, evaluated while idle.
    always_comb begin
        req_error = 1'b0;
        case (req_size)
            SIZE_BYTE: req_error = 1'b0;
            SIZE_HALF: req_error = req_addr[0];
            SIZE_WORD: req_error = (req_addr[1:0] != 2'b00);
            default:   req_error = 1'b1;
        endcase
        if (req_addr >= ADDR_LIMIT) begin
            req_error = 1'b1;
        end
        if (req_write && (req_addr < DATA_LIMIT)) begin
            req_error = 1'b1;
        end
    end

    // Pulls the addressed byte/half out of a memory word and right-justifies it.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        sign_ext,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = {{24{sign_ext & b[7]}}, b};
            SIZE_HALF: r = {{16{sign_ext & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replaces only the addressed byte/half lane of the word just read.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [15:0] data
    );
        logic [31:0] r;
        r = word;
        if (size == SIZE_BYTE) begin
            r[{lane, 3'b000} +: 8] = data[7:0];
        end else if (lane[1]) begin
            r[31:16] = data;
        end else begin
            r[15:0] = data;
        end
        return r;
    endfunction

    // Main sequencer. Every output is registered: the memory address is set on
    // the accept edge so it is stable for the whole READ or WRITE cycle. The
    // merged store word is formed on the READ edge directly from the
    // combinational read data, so it is already valid when WRITE begins.
    // Async reset clears the write strobe at once and aborts any request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_rdata       <= 32'h0;
            mem_write_enable <= 1'b0;
            mem_address      <= 32'h0;
            mem_write_data   <= 32'h0;
            cap_write        <= 1'b0;
            cap_size         <= 2'b00;
            cap_signed       <= 1'b0;
            cap_lane         <= 2'b00;
            cap_wdata        <= 16'h0;
        end else begin
            resp_valid       <= 1'b0;
            mem_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        cap_write   <= req_write;
                        cap_size    <= req_size;
                        cap_signed  <= req_signed;
                        cap_lane    <= req_addr[1:0];
                        cap_wdata   <= req_wdata[15:0];
                        mem_address <= {req_addr[31:2], 2'b00};
                        if (req_error) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            state            <= WRITE;
                            mem_write_enable <= 1'b1;
                            mem_write_data   <= req_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (cap_write) begin
                        state            <= WRITE;
                        mem_write_enable <= 1'b1;
                        mem_write_data   <= merge_store(mem_read_data, cap_size,
                                                        cap_lane, cap_wdata);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= extract_load(mem_read_data, cap_size,
                                                   cap_signed, cap_lane);
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit
// ----------------------------------------------------------------------------
// Randomized scoreboard bench for load_store_unit. A byte-addressed reference
// model predicts each response when a request is accepted. A monitor compares
// every DUT response, write strobe, ready level and latency against the
// predictions. The bench also holds the word memory the unit talks to.
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_WORDS = 512;
    localparam int DATA_BASE = 1024;
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(
        .MEM_WORDS(MEM_WORDS),
        .DATA_BASE(DATA_BASE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_error(resp_error),
        .resp_rdata(resp_rdata),
        .mem_write_enable(mem_write_enable),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          writes;
        int          latency;
        int          accept_cyc;
        logic [31:0] waddr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int          checks = 0;
    int          errors = 0;
    int          neg_count = 0;
    int          writes_seen = 0;
    bit          mon_enable = 1'b0;

    // Deterministic initial memory contents shared by memory and model.
    function automatic logic [31:0] init_word(input int i);
        if (i == 300) return 32'h80FF_1234;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory seen by the DUT: combinational read, write on posedge.
    assign mem_read_data = (mem_address < ADDR_LIMIT) ? mem[mem_address[10:2]] : 32'h0;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write_enable && (mem_address < ADDR_LIMIT))
                mem[mem_address[10:2]] <= mem_write_data;
        end
    end

    // Reference model: memory as a flat byte array, little-endian.
    function automatic logic [7:0] get_byte(input int a);
        return ref_mem[a / 4][8 * (a % 4) +: 8];
    endfunction

    function automatic void set_byte(input int a, input logic [7:0] v);
        ref_mem[a / 4][8 * (a % 4) +: 8] = v;
    endfunction

    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        longint      la;
        logic [31:0] v;
        la = longint'(a);
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err = (sz == 2'd3) || ((la % n) != 0) || (la >= MEM_WORDS * 4) ||
                (w && (la < DATA_BASE));
        e.rdata      = 32'h0;
        e.writes     = 0;
        e.accept_cyc = 0;
        e.waddr      = {a[31:2], 2'b00};
        if (e.err) begin
            e.latency = 1;
        end else if (w) begin
            for (int i = 0; i < n; i++) set_byte(int'(la) + i, wd[8 * i +: 8]);
            e.writes  = 1;
            e.latency = (n == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8 * i +: 8] = get_byte(int'(la) + i);
            if (sg && (n < 4) && v[8 * n - 1])
                for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
            e.rdata   = v;
            e.latency = 2;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Presents a request (caller is at a negedge) and waits for acceptance.
    // req_valid stays high afterwards so the next request overlaps busy cycles.
    task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd);
        int   waited;
        exp_t e;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waited     = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: req_ready=0, expected 1 within 20 cycles");
            return;
        end
        @(posedge clk);
        e = model(w, sz, sg, a, wd);
        e.accept_cyc = neg_count;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waited;
        req_valid = 1'b0;
        waited    = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset asserted while a half store is in its WRITE cycle.
    task automatic reset_mid_op();
        int waited;
        drain();
        @(negedge clk);
        mon_enable = 1'b0;
        check_output("rst_ready_before", 32'(req_ready), 32'd1);
        req_write  = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 32'd1026;
        req_wdata  = $urandom;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waited    = 0;
        while (!mem_write_enable && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output("rst_strobe_seen", 32'(mem_write_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("rst_strobe_drop", 32'(mem_write_enable), 32'd0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_ready", 32'(req_ready), 32'd1);
        check_output("rst_mem_address", mem_address, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_output("rst_no_resp", 32'(resp_valid), 32'd0);
            check_output("rst_ready_after", 32'(req_ready), 32'd1);
        end
        check_output("rst_target_word", mem[256], ref_mem[256]);
        mon_enable = 1'b1;
    endtask

    // Monitor: compares ready, write strobes and responses against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_count++;
            if (mon_enable) begin
                if (mem_write_enable) begin
                    writes_seen++;
                    if (exp_q.size() != 0) begin
                        check_output("write_addr", mem_address, exp_q[0].waddr);
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: mem_write_enable=1, expected 0");
                    end
                end
                check_output("req_ready", 32'(req_ready),
                             (exp_q.size() == 0) ? 32'd1 : 32'd0);
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_resp: resp_valid=1, expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        check_output("resp_error", 32'(resp_error), 32'(e.err));
                        check_output("resp_rdata", resp_rdata, e.rdata);
                        check_output("latency", 32'(neg_count - e.accept_cyc), 32'(e.latency));
                        check_output("write_count", 32'(writes_seen), 32'(e.writes));
                    end
                    writes_seen = 0;
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int          bad;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

        #1 reset_n = 1'b0;
        #3;
        check_output("reset_ready", 32'(req_ready), 32'd1);
        check_output("reset_resp_valid", 32'(resp_valid), 32'd0);
        check_output("reset_resp_error", 32'(resp_error), 32'd0);
        check_output("reset_resp_rdata", resp_rdata, 32'h0);
        check_output("reset_write_enable", 32'(mem_write_enable), 32'd0);
        check_output("reset_mem_address", mem_address, 32'h0);
        check_output("reset_mem_write_data", mem_write_data, 32'h0);
        repeat (3) @(negedge clk);
        reset_n    = 1'b1;
        mon_enable = 1'b1;
        @(negedge clk);

        // Directed loads, sub-word store and error cases around word 300.
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'd1200, 32'h0);
        idle_cycles(2);
        apply_stimulus(1'b0, 2'd0, 1'b1, 32'd1201, 32'h0);
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'd1202, 32'h0);
        apply_stimulus(1'b0, 2'd1, 1'b0, 32'd1202, 32'h0);
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'd1203, 32'h0000_00AB);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'd1200, 32'h0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'd1202, 32'h0);
        apply_stimulus(1'b0, 2'd1, 1'b0, 32'd1201, 32'h0);
        apply_stimulus(1'b0, 2'd2, 1'b0, 32'd2048, 32'h0);
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'd2048, 32'h55);
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'd16, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 2'd3, 1'b0, 32'd1200, 32'h0);
        apply_stimulus(1'b1, 2'd2, 1'b0, 32'd1024, 32'h1357_9BDF);
        apply_stimulus(1'b1, 2'd1, 1'b0, 32'd2046, 32'h0000_C0DE);
        apply_stimulus(1'b0, 2'd1, 1'b1, 32'd2046, 32'h0);
        apply_stimulus(1'b1, 2'd0, 1'b0, 32'd1023, 32'h77);
        idle_cycles(1);

        reset_mid_op();

        // Random traffic, mostly legal, with occasional idle gaps.
        for (int t = 0; t < 400; t++) begin
            w  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(2048 - $urandom_range(0, 7));
            else if (w)      a = 32'($urandom_range(960, 2047));
            else             a = 32'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            apply_stimulus(w, sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        drain();
        @(negedge clk);

        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (bad <= 4)
                    $display("[TB] FAIL mem_word[%0d]: got 0x%08h, expected 0x%08h",
                             i, mem[i], ref_mem[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
